// File: rtl/kbd_mmio_ctrl_pkg.sv
// Shared constants and types for the memory-mapped keyboard controller.
package kbd_mmio_ctrl_pkg;
    localparam int WORD_SIZE  = 16;
    localparam int ASCII_SIZE = 8;

    localparam logic [WORD_SIZE-1:0] KEYBOARD_ADD      = 16'hFFF0;
    localparam logic [WORD_SIZE-1:0] KEYBOARD_STAT_ADD = KEYBOARD_ADD + 16'd1;

    localparam int KBD_STAT_OVF_BIT = 8;
    localparam int KBD_STAT_ERR_BIT = 9;
    localparam int KBD_STAT_NE_BIT  = 10;

    typedef enum logic {
        KBD_IDLE = 1'b0,
        KBD_ACK  = 1'b1
    } kbd_state_t;
endpackage

// File: rtl/kbd_mmio_ctrl_fifo.sv
// Synchronous character FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
module kbd_char_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push_s;
    logic          do_pop_s;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/kbd_mmio_ctrl.sv
// Keyboard controller: synchronizes the PS/2 strobes, buffers characters and
// answers CPU reads of the data and status addresses with a one-cycle ack.
module kbd_mmio_ctrl
    import kbd_mmio_ctrl_pkg::*;
#(
    parameter int                   DEPTH     = 8,
    parameter logic [WORD_SIZE-1:0] DATA_ADDR = KEYBOARD_ADD,
    parameter logic [WORD_SIZE-1:0] STAT_ADDR = KEYBOARD_STAT_ADD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [ASCII_SIZE-1:0] key_code,
    input  logic                  key_error,
    input  logic [WORD_SIZE-1:0]  bus_addr,
    input  logic                  bus_rd,
    output logic [WORD_SIZE-1:0]  bus_rd_data,
    output logic                  bus_rd_ack,
    output logic                  kbd_irq
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    kbd_state_t            state_q;
    logic [2:0]            kv_sync_q;
    logic [2:0]            ke_sync_q;
    logic                  ovf_flag_q, ovf_flag_d;
    logic                  err_flag_q, err_flag_d;
    logic                  ack_q;
    logic [WORD_SIZE-1:0]  rd_data_q;
    logic                  irq_q;

    logic                  push_s, pop_s, rd_take_s, data_rd_s, stat_rd_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [ASCII_SIZE-1:0] fifo_dout_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [WORD_SIZE-1:0]  stat_word_s;
    logic [WORD_SIZE-1:0]  data_word_s;

    kbd_char_fifo #(.DEPTH(DEPTH), .DW(ASCII_SIZE)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (key_code),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Two synchronizer stages plus one history stage for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kv_sync_q <= 3'b000;
            ke_sync_q <= 3'b000;
        end else begin
            kv_sync_q <= {kv_sync_q[1:0], key_valid};
            ke_sync_q <= {ke_sync_q[1:0], key_error};
        end
    end

    // Read decode, response words and sticky-flag next state (set beats clear).
    always_comb begin
        push_s    = kv_sync_q[1] && !kv_sync_q[2];
        rd_take_s = (state_q == KBD_IDLE) && bus_rd &&
                    ((bus_addr == DATA_ADDR) || (bus_addr == STAT_ADDR));
        data_rd_s = rd_take_s && (bus_addr == DATA_ADDR);
        stat_rd_s = rd_take_s && (bus_addr == STAT_ADDR);
        pop_s     = data_rd_s && !fifo_empty_s;

        data_word_s = fifo_empty_s ? '0 : WORD_SIZE'(fifo_dout_s);

        stat_word_s                   = '0;
        stat_word_s[CNT_W-1:0]        = fifo_count_s;
        stat_word_s[KBD_STAT_OVF_BIT] = ovf_flag_q;
        stat_word_s[KBD_STAT_ERR_BIT] = err_flag_q;
        stat_word_s[KBD_STAT_NE_BIT]  = !fifo_empty_s;

        if (push_s && fifo_full_s && !pop_s) begin
            ovf_flag_d = 1'b1;
        end else if (stat_rd_s) begin
            ovf_flag_d = 1'b0;
        end else begin
            ovf_flag_d = ovf_flag_q;
        end

        if (ke_sync_q[1] && !ke_sync_q[2]) begin
            err_flag_d = 1'b1;
        end else if (stat_rd_s) begin
            err_flag_d = 1'b0;
        end else begin
            err_flag_d = err_flag_q;
        end
    end

    // Sticky flags and interrupt, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_flag_q <= 1'b0;
            err_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ovf_flag_q <= ovf_flag_d;
            err_flag_q <= err_flag_d;
            irq_q      <= !fifo_empty_s;
        end
    end

    // Bus FSM: response captured on acceptance, presented for one ACK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= KBD_IDLE;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            case (state_q)
                KBD_IDLE: begin
                    if (rd_take_s) begin
                        state_q   <= KBD_ACK;
                        ack_q     <= 1'b1;
                        rd_data_q <= data_rd_s ? data_word_s : stat_word_s;
                    end else begin
                        ack_q     <= 1'b0;
                        rd_data_q <= '0;
                    end
                end
                KBD_ACK: begin
                    state_q   <= KBD_IDLE;
                    ack_q     <= 1'b0;
                    rd_data_q <= '0;
                end
                default: begin
                    state_q   <= KBD_IDLE;
                    ack_q     <= 1'b0;
                    rd_data_q <= '0;
                end
            endcase
        end
    end

    assign bus_rd_ack  = ack_q;
    assign bus_rd_data = rd_data_q;
    assign kbd_irq     = irq_q;
endmodule

// File: tb/tb_kbd_mmio_ctrl.sv
// Scoreboard bench for kbd_mmio_ctrl: a queue-based reference model predicts
// every read response and the interrupt level; a monitor compares them.
module tb_kbd_mmio_ctrl;
    import kbd_mmio_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam logic [15:0] DA = KEYBOARD_ADD;
    localparam logic [15:0] SA = KEYBOARD_STAT_ADD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_error = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic [15:0] bus_addr = 16'h0000;
    logic        bus_rd = 1'b0;
    logic [15:0] bus_rd_data;
    logic        bus_rd_ack;
    logic        kbd_irq;

    int n_cmp = 0;
    int n_bad = 0;

    kbd_mmio_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_error   (key_error),
        .bus_addr    (bus_addr),
        .bus_rd      (bus_rd),
        .bus_rd_data (bus_rd_data),
        .bus_rd_ack  (bus_rd_ack),
        .kbd_irq     (kbd_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: characters in a queue, strobes seen through a delay line.
    byte unsigned mq[$];
    logic [15:0]  expq[$];
    bit           m_ovf, m_err, m_busy, m_ack, m_irq;
    bit           kv1, kv2, kv3, ke1, ke2, ke3;
    int           m_n;
    bit           m_push, m_eset, m_take;
    logic [15:0]  m_r;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            expq.delete();
            {m_ovf, m_err, m_busy, m_ack, m_irq} = 5'b00000;
            {kv1, kv2, kv3, ke1, ke2, ke3} = 6'b000000;
        end else begin
            m_n    = mq.size();
            m_push = kv2 && !kv3;
            m_eset = ke2 && !ke3;
            m_irq  = (m_n != 0);
            m_take = !m_busy && bus_rd && (bus_addr == DA || bus_addr == SA);
            if (m_take) begin
                if (bus_addr == DA) begin
                    m_r = (m_n > 0) ? 16'(mq.pop_front()) : 16'h0000;
                end else begin
                    m_r = {5'b00000, (m_n != 0), m_err, m_ovf, 8'(m_n)};
                    m_ovf = 1'b0;
                    m_err = 1'b0;
                end
                expq.push_back(m_r);
            end
            m_ack  = m_take;
            m_busy = m_take;
            if (m_push) begin
                if (mq.size() < DEPTH) mq.push_back(key_code);
                else m_ovf = 1'b1;
            end
            if (m_eset) m_err = 1'b1;
            kv3 = kv2; kv2 = kv1; kv1 = key_valid;
            ke3 = ke2; ke2 = ke1; ke1 = key_error;
        end
    end

    // Monitor: compares outputs just after each active edge.
    always @(posedge clk) begin
        #1;
        chk("ack", 16'(bus_rd_ack), 16'(m_ack));
        chk("irq", 16'(kbd_irq), 16'(m_irq));
        if (bus_rd_ack) begin
            if (expq.size() == 0) begin
                chk("unexpected_ack", 16'h0001, 16'h0000);
            end else begin
                chk("rd_data", bus_rd_data, expq.pop_front());
            end
        end else begin
            chk("idle_data", bus_rd_data, 16'h0000);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] c, input int hold);
        key_code  = c;
        key_valid = 1'b1;
        cyc(hold);
        key_valid = 1'b0;
        cyc(3);
    endtask

    task automatic rd(input logic [15:0] a, input int hold);
        bus_addr = a;
        bus_rd   = 1'b1;
        cyc(hold);
        bus_rd   = 1'b0;
        cyc(1);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Single character round trip.
        press(8'h41, 4);
        cyc(2);
        rd(DA, 1);
        cyc(3);

        // Fill exactly, status, drain, then one read of the empty FIFO.
        for (int i = 0; i < 8; i++) press(8'(8'h31 + i), 3);
        rd(SA, 1);
        for (int i = 0; i < 9; i++) rd(DA, 1);

        // Overflow by one, sticky flag cleared by the first status read.
        for (int i = 0; i < 9; i++) press(8'(8'h50 + i), 3);
        rd(SA, 1);
        rd(SA, 1);
        for (int i = 0; i < 9; i++) rd(DA, 1);

        // Push lands on the same edge as a pop of a full FIFO.
        for (int i = 0; i < 8; i++) press(8'(8'h61 + i), 3);
        key_code  = 8'h7A;
        key_valid = 1'b1;
        cyc(2);
        bus_addr  = DA;
        bus_rd    = 1'b1;
        cyc(1);
        bus_rd    = 1'b0;
        cyc(3);
        key_valid = 1'b0;
        cyc(3);
        rd(SA, 1);
        for (int i = 0; i < 9; i++) rd(DA, 1);

        // Error flag set on the same edge as the clearing status read.
        key_error = 1'b1;
        cyc(4);
        key_error = 1'b0;
        cyc(4);
        key_error = 1'b1;
        cyc(2);
        bus_addr  = SA;
        bus_rd    = 1'b1;
        cyc(1);
        bus_rd    = 1'b0;
        cyc(3);
        key_error = 1'b0;
        cyc(3);
        rd(SA, 1);
        rd(SA, 1);

        // Reset while an acknowledge is on the bus.
        for (int i = 0; i < 3; i++) press(8'(8'h21 + i), 3);
        bus_addr = DA;
        bus_rd   = 1'b1;
        cyc(1);
        bus_rd   = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_ack", 16'(bus_rd_ack), 16'h0000);
        chk("rst_irq", 16'(kbd_irq), 16'h0000);
        chk("rst_data", bus_rd_data, 16'h0000);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        rd(SA, 1);
        rd(16'h0000, 1);
        cyc(3);

        // Randomized traffic: key presses and reads run concurrently.
        fork
            begin
                repeat (30) begin
                    press(8'($urandom_range(32, 126)), $urandom_range(3, 6));
                    cyc($urandom_range(0, 4));
                end
            end
            begin
                repeat (40) begin
                    key_error = 1'($urandom_range(0, 1));
                    cyc($urandom_range(3, 12));
                end
                key_error = 1'b0;
            end
            begin
                repeat (90) begin
                    int sel;
                    sel = $urandom_range(0, 9);
                    if (sel < 5)      rd(DA, $urandom_range(1, 3));
                    else if (sel < 8) rd(SA, $urandom_range(1, 2));
                    else              rd(16'($urandom), 1);
                    cyc($urandom_range(0, 3));
                end
            end
        join

        cyc(6);
        for (int i = 0; i < 10; i++) rd(DA, 1);
        rd(SA, 1);
        cyc(4);
        chk("pending_acks", 16'(expq.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
